alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Command front-end placed directly upstream of the serial ALU. It accepts one complete operation (opcode plus two 8-bit operands) over a valid/ready handshake. It then replays that operation into the ALU's serial BEGIN/op_code/inbus protocol, captures the result byte(s) on END, and returns a 16-bit response over a second valid/ready handshake. A watchdog bounds the wait for END and reports an error if it expires.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles spent waiting for each alu_end pulse before aborting (must be >= 2)
DATA_W, 8, ALU operand/bus width; rsp_data is 2*DATA_W

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div
cmd_a  in  DATA_W  operand A
cmd_b  in  DATA_W  operand B
alu_begin  out  1  drives ALU BEGIN
alu_op_code  out  2  drives ALU op_code
alu_inbus  out  DATA_W  drives ALU inbus
alu_outbus  in  DATA_W  ALU result bus
alu_end  in  1  ALU END, one-cycle pulse per result byte
rsp_valid  out  1  response present
rsp_ready  in  1  downstream accepts response
rsp_data  out  2*DATA_W  result; add/sub use {8'h00, r0}; mul uses {hi, lo}; div uses {rem, quot}
rsp_err  out  1  timeout occurred; rsp_data is 0

Behaviour:
- Reset (reset low, async): state IDLE. cmd_ready=1. alu_begin=0, alu_op_code=0, alu_inbus=0, rsp_valid=0, rsp_data=0, rsp_err=0. Watchdog cleared.
- FSM states: IDLE, START, LOAD_A, LOAD_B, WAIT_R0, WAIT_R1, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch op/a/b and go to START. cmd_ready=0 in every other state.
- START (1 cycle): alu_begin=1, alu_op_code=op, alu_inbus=0.
- LOAD_A (1 cycle): alu_begin=1, alu_inbus=a.
- LOAD_B (1 cycle): alu_begin=0, alu_inbus=b. Then go to WAIT_R0 with the watchdog cleared.
- alu_op_code stays at the latched op from START through the end of RESP; it is 0 in IDLE. alu_inbus is 0 in every state except LOAD_A and LOAD_B.
- WAIT_R0: the watchdog increments each cycle. On alu_end=1, capture alu_outbus as r0.
  - op 00/01: go to RESP.
  - op 10/11: go to WAIT_R1 with the watchdog cleared.
- WAIT_R1: on alu_end=1, capture r1 and go to RESP.
- Timeout: in either WAIT state, if alu_end is still 0 when the watchdog reaches TIMEOUT_CYCLES-1, go to RESP with rsp_err=1 and rsp_data=0.
- If alu_end=1 arrives on the same cycle the watchdog expires, alu_end wins: the result is valid and rsp_err=0.
- alu_end is ignored in IDLE, START, LOAD_A, LOAD_B and RESP.
- RESP: rsp_valid=1. rsp_data and rsp_err are held stable until rsp_valid&&rsp_ready, then return to IDLE.
  - rsp_ready already high on entry still costs one cycle in RESP.
  - cmd_ready rises on the cycle after the handshake, so there is no command/response overlap.
- Command latency: cmd handshake at cycle 0, alu_begin high in cycles 1–2, operand B on cycle 3, earliest END sampled on cycle 4, rsp_valid on cycle 5.
- rsp_data/rsp_err keep their last value in IDLE and are cleared only by reset.
- Reset asserted mid-operation: immediate abort with no response; the ALU sees alu_begin drop to 0.

Decomposition:
- Package alu_seq_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_DIV=2'b11
  - FSM state encoding
  - helper constant marking which opcodes return two bytes
- Sub-module seq_watchdog: clearable up-counter with an expire flag at TIMEOUT_CYCLES-1, same clock and active-low async reset.
- Everything else stays in alu_sequencer.

Test Plan:
- Add: cmd op=00, a=3, b=2. Bench ALU model pulses alu_end with outbus=5 → alu_begin high exactly 2 cycles, alu_inbus 3 then 2, rsp_data=16'h0005, rsp_err=0.
- Mul: op=10, a=7, b=40. Model returns lo=8'h18 then hi=8'h01 → rsp_data=16'h0118. Div: op=11, a=23, b=5, model returns quot 4 then rem 3 → rsp_data=16'h0304.
- Timeout: op=00, model never asserts alu_end, TIMEOUT_CYCLES=8 → rsp_valid 8 cycles after entering WAIT_R0, rsp_err=1, rsp_data=0. Repeat with alu_end exactly on the expiry cycle → rsp_err=0.
- Backpressure: rsp_ready held low 10 cycles → rsp_valid/rsp_data stable, cmd_ready=0 throughout, a new cmd_valid is not accepted until the cycle after the handshake.
- Reset mid-op: assert reset during WAIT_R1 of a mul → all outputs return to reset values asynchronously, no response emitted, the next add completes correctly.
- Back-to-back: two commands (add 10+20, sub 9-4) with cmd_valid held high → responses 16'h001E then 16'h0005 in order, op_code stable per operation.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM encoding and opcode properties for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    LOAD_A  = 3'd2,
    LOAD_B  = 3'd3,
    WAIT_R0 = 3'd4,
    WAIT_R1 = 3'd5,
    RESP    = 3'd6
  } seq_state_t;

  // One bit per opcode; set where the ALU returns a second result byte (mul, div).
  localparam logic [3:0] TWO_BYTE_OPS = 4'b1100;

  function automatic logic is_two_byte(input logic [1:0] op);
    return TWO_BYTE_OPS[op];
  endfunction

endpackage

// File: rtl/alu_sequencer_watchdog.sv
// seq_watchdog: clearable up-counter that flags expiry at TIMEOUT_CYCLES-1 and
// holds there until cleared.
module seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en && !expire)
      count <= count + 1'b1;
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one op over valid/ready, replays it into the serial ALU
// BEGIN/op_code/inbus protocol and returns the result byte(s) as one response.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int DATA_W         = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [DATA_W-1:0]   cmd_a,
  input  logic [DATA_W-1:0]   cmd_b,
  output logic                alu_begin,
  output logic [1:0]          alu_op_code,
  output logic [DATA_W-1:0]   alu_inbus,
  input  logic [DATA_W-1:0]   alu_outbus,
  input  logic                alu_end,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*DATA_W-1:0] rsp_data,
  output logic                rsp_err
);

  // state   | meaning
  // IDLE    | ready for a command; op_code bus parked at 0
  // START   | BEGIN high, op_code presented, inbus 0
  // LOAD_A  | BEGIN high, operand A on inbus
  // LOAD_B  | BEGIN low, operand B on inbus
  // WAIT_R0 | waiting for first END (result / low byte / quotient)
  // WAIT_R1 | waiting for second END (high byte / remainder)
  // RESP    | response presented until rsp_ready

  seq_state_t        state, state_nxt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q, r0_q;
  logic              wd_clr, wd_en, wd_expire;
  logic              in_wait;

  assign in_wait = (state == WAIT_R0) || (state == WAIT_R1);
  assign wd_en   = in_wait;
  // Restart the count for every END we wait on, including the WAIT_R0 -> WAIT_R1 hop.
  assign wd_clr  = !in_wait || (state == WAIT_R0 && alu_end);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .expire(wd_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    alu_begin   = 1'b0;
    alu_op_code = op_q;
    alu_inbus   = '0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready   = 1'b1;
        alu_op_code = 2'b00;
        if (cmd_valid)
          state_nxt = START;
      end
      START: begin
        alu_begin = 1'b1;
        state_nxt = LOAD_A;
      end
      LOAD_A: begin
        alu_begin = 1'b1;
        alu_inbus = a_q;
        state_nxt = LOAD_B;
      end
      LOAD_B: begin
        alu_inbus = b_q;
        state_nxt = WAIT_R0;
      end
      WAIT_R0: begin
        // END beats a simultaneous expiry.
        if (alu_end)
          state_nxt = is_two_byte(op_q) ? WAIT_R1 : RESP;
        else if (wd_expire)
          state_nxt = RESP;
      end
      WAIT_R1: begin
        if (alu_end || wd_expire)
          state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: begin
        alu_op_code = 2'b00;
        state_nxt   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      r0_q     <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            a_q  <= cmd_a;
            b_q  <= cmd_b;
          end
        end
        WAIT_R0: begin
          if (alu_end) begin
            r0_q <= alu_outbus;
            if (!is_two_byte(op_q)) begin
              rsp_data <= {{DATA_W{1'b0}}, alu_outbus};
              rsp_err  <= 1'b0;
            end
          end else if (wd_expire) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        WAIT_R1: begin
          if (alu_end) begin
            rsp_data <= {alu_outbus, r0_q};
            rsp_err  <= 1'b0;
          end else if (wd_expire) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized scoreboard bench for alu_sequencer with a behavioural serial-ALU model.
module tb_alu_sequencer;

  localparam int TMO = 8;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        alu_begin;
  logic [1:0]  alu_op_code;
  logic [7:0]  alu_inbus, alu_outbus;
  logic        alu_end;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;

  alu_sequencer #(.TIMEOUT_CYCLES(TMO), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_begin(alu_begin), .alu_op_code(alu_op_code), .alu_inbus(alu_inbus),
    .alu_outbus(alu_outbus), .alu_end(alu_end),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  typedef struct { logic [15:0] data; logic err; int lat; int hs; } exp_t;
  typedef struct { int d0; int d1; bit s0; bit s1; bit glitch; } alu_cfg_t;

  exp_t     sb_q[$];
  alu_cfg_t alu_q[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_hold = 0;
  int   rcyc = 0;
  int   last_rsp_hs = -100;
  bit   in_resp = 0;
  bit   after_hs = 0;
  logic [1:0]  cur_op = 2'b00;
  logic [15:0] held_data;
  logic        held_err;
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_of(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    case (op)
      2'b00: begin t = a + b; return {8'h00, t}; end
      2'b01: begin t = a - b; return {8'h00, t}; end
      2'b10: return 16'(a) * 16'(b);
      default: return {8'(a % b), 8'(a / b)};
    endcase
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit");
  end

  // Downstream sink: stalls each response for rsp_hold cycles.
  initial begin
    rsp_ready = 0;
    forever begin
      @(posedge clk); #2;
      rsp_ready = (rsp_hold == 0) || (rcyc >= rsp_hold);
    end
  end

  // Serial ALU model: decodes BEGIN/op_code/inbus, then pulses END per result byte.
  initial begin
    int nbeg, t0, t1, tg;
    bit prev_beg;
    logic [1:0] mop;
    logic [7:0] ma, mb, v0, v1;
    logic [15:0] prod;
    alu_cfg_t c;
    nbeg = 0; t0 = -1; t1 = -1; tg = -1; prev_beg = 0;
    mop = 0; ma = 0; mb = 0; v0 = 0; v1 = 0;
    alu_end = 0; alu_outbus = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        nbeg = 0; t0 = -1; t1 = -1; tg = -1; prev_beg = 0;
      end else begin
        if (alu_begin) begin
          nbeg++;
          if (nbeg == 1) begin
            mop = alu_op_code;
            chk("inbus_start", alu_inbus, 0);
          end else if (nbeg == 2) begin
            ma = alu_inbus;
          end
        end else if (prev_beg) begin
          chk("begin_len", nbeg, 2);
          mb = alu_inbus;
          nbeg = 0;
          if (alu_q.size() > 0) c = alu_q.pop_front();
          else c = '{d0: 1, d1: 1, s0: 1, s1: 1, glitch: 0};
          prod = 16'(ma) * 16'(mb);
          case (mop)
            2'b00: begin v0 = ma + mb; v1 = 0; end
            2'b01: begin v0 = ma - mb; v1 = 0; end
            2'b10: begin v0 = prod[7:0]; v1 = prod[15:8]; end
            default: begin
              v0 = (mb == 0) ? 8'hFF : ma / mb;
              v1 = (mb == 0) ? ma : ma % mb;
            end
          endcase
          t0 = c.s0 ? -1 : cyc + c.d0;
          t1 = (c.s0 || c.s1 || !mop[1]) ? -1 : cyc + c.d0 + 1 + c.d1;
          tg = c.glitch ? cyc : -1;
        end else begin
          chk("inbus_quiet", alu_inbus, 0);
        end
        prev_beg = alu_begin;
      end
      if (cyc == t0) begin alu_end = 1; alu_outbus = v0; end
      else if (cyc == t1) begin alu_end = 1; alu_outbus = v1; end
      else if (cyc == tg) begin alu_end = 1; alu_outbus = 8'hEE; end
      else begin alu_end = 0; alu_outbus = 8'($urandom); end
    end
  end

  // Monitor: protocol checks every cycle, pops the scoreboard on each new response.
  always @(negedge clk) begin
    if (!reset) begin
      in_resp = 0; after_hs = 0; rcyc = 0;
    end else begin
      if (cmd_ready) chk("idle_outs", {rsp_valid, alu_begin, alu_op_code, alu_inbus}, 0);
      else chk("op_code_hold", alu_op_code, cur_op);
      if (after_hs) begin
        chk("post_hs_ready", {cmd_ready, rsp_valid}, 2'b10);
        after_hs = 0;
      end
      if (rsp_valid) begin
        if (!in_resp) begin
          if (sb_q.size() == 0) chk("unexpected_rsp", 32'(rsp_valid), 0);
          else begin
            mon_e = sb_q.pop_front();
            chk("rsp_data", rsp_data, mon_e.data);
            chk("rsp_err", rsp_err, mon_e.err);
            chk("rsp_latency", cyc - mon_e.hs, mon_e.lat);
          end
          held_data = rsp_data; held_err = rsp_err;
          in_resp = 1; rcyc = 1;
        end else begin
          chk("rsp_stable", {rsp_err, rsp_data}, {held_err, held_data});
          rcyc++;
        end
        if (rsp_ready) begin
          in_resp = 0; rcyc = 0; after_hs = 1; last_rsp_hs = cyc;
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int d0, input int d1, input bit s0, input bit s1, input bit g,
                      output int hs);
    exp_t e;
    alu_cfg_t c;
    int n;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      chk("cmd_accept", 32'(cmd_ready), 1);
      hs = -1;
      return;
    end
    hs = cyc;
    cur_op = op;
    c = '{d0: d0, d1: d1, s0: s0, s1: s1, glitch: g};
    alu_q.push_back(c);
    e.hs = hs;
    if (s0) e.lat = 4 + TMO;
    else if (!op[1]) e.lat = 4 + d0;
    else if (s1) e.lat = 4 + d0 + TMO;
    else e.lat = 5 + d0 + d1;
    e.err  = s0 || (op[1] && s1);
    e.data = e.err ? 16'h0000 : exp_of(op, a, b);
    sb_q.push_back(e);
  endtask

  task automatic idle_cmd();
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() > 0 || in_resp) && n < 300) begin @(negedge clk); #1; n++; end
    chk("drain", sb_q.size() + int'(in_resp), 0);
  endtask

  initial begin
    int hs, hs2;
    logic [1:0] op;
    logic [7:0] a, b;
    reset = 0; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0;
    #12;
    chk("reset_vals", {cmd_ready, alu_begin, alu_op_code, alu_inbus, rsp_valid, rsp_err, rsp_data}, 30'h2000_0000);
    @(posedge clk); #3 reset = 1;

    // Directed: add, mul, div
    send(2'b00, 8'd3, 8'd2, 1, 1, 0, 0, 0, hs); idle_cmd(); wait_drain();
    send(2'b10, 8'd7, 8'd40, 1, 1, 0, 0, 0, hs); idle_cmd(); wait_drain();
    send(2'b11, 8'd23, 8'd5, 2, 3, 0, 0, 1, hs); idle_cmd(); wait_drain();

    // Watchdog: silent, END on expiry cycle, expiry on second byte, silent second byte
    send(2'b00, 8'd11, 8'd12, 1, 1, 1, 0, 0, hs); idle_cmd(); wait_drain();
    send(2'b00, 8'd11, 8'd12, TMO, 1, 0, 0, 0, hs); idle_cmd(); wait_drain();
    send(2'b10, 8'd200, 8'd3, 3, TMO - 1, 0, 0, 0, hs); idle_cmd(); wait_drain();
    send(2'b11, 8'd99, 8'd7, 2, 1, 0, 1, 0, hs); idle_cmd(); wait_drain();

    // Backpressure with the next command already waiting
    rsp_hold = 10;
    send(2'b00, 8'd100, 8'd50, 2, 1, 0, 0, 0, hs);
    send(2'b01, 8'd200, 8'd55, 1, 1, 0, 0, 0, hs2);
    chk("accept_after_rsp_hs", hs2 - last_rsp_hs, 1);
    idle_cmd(); wait_drain();
    rsp_hold = 0;

    // Back-to-back with cmd_valid held high
    send(2'b00, 8'd10, 8'd20, 1, 1, 0, 0, 0, hs);
    send(2'b01, 8'd9, 8'd4, 3, 1, 0, 0, 0, hs2);
    idle_cmd(); wait_drain();

    // Reset in WAIT_R1 of a mul
    send(2'b10, 8'd7, 8'd40, 2, 1, 0, 1, 0, hs);
    idle_cmd();
    repeat (6) @(posedge clk);
    #3 reset = 0;
    #1;
    chk("reset_midop", {cmd_ready, alu_begin, alu_op_code, alu_inbus, rsp_valid, rsp_err, rsp_data}, 30'h2000_0000);
    sb_q.delete();
    alu_q.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1;
    repeat (20) @(posedge clk);
    send(2'b00, 8'h80, 8'h90, 1, 1, 0, 0, 0, hs); idle_cmd(); wait_drain();

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(3, 0));
      a = 8'($urandom);
      b = 8'($urandom);
      if (op == 2'b11 && b == 0) b = 8'd1;
      rsp_hold = $urandom_range(3, 0);
      send(op, a, b, $urandom_range(TMO, 1), $urandom_range(TMO - 1, 1),
           $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0, $urandom_range(1, 0) == 1, hs);
      if ($urandom_range(1, 0) == 1) begin
        idle_cmd();
        repeat ($urandom_range(3, 0)) @(posedge clk);
      end
    end
    idle_cmd();
    wait_drain();
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
